// File: rtl/MainCtrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS main controller:
// state encoding, opcode map, ALU/mux select codes and the output bundle.
package MainCtrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } CtrlState_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       illegal_op;
  } ctrl_out_t;

  function automatic logic is_legal_opcode(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/main_control_fsm_if.sv
// Controller <-> datapath/memory signal bundle. The master side is the
// controller; the slave side is the datapath and memory it steers.
interface main_control_fsm_if;

  logic [5:0] opcode;
  logic       mem_ready;
  logic       mem_req;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic       pcwrite;
  logic       branch;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, pcwrite, branch, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, pcwrite, branch, illegal_op
  );

endinterface

// File: rtl/main_control_outdec.sv
// Combinational decode of controller state into datapath strobes/selects.
// Only irwrite/pcwrite (FETCH) and illegal_op (DECODE) look at inputs.
module main_control_outdec
  import MainCtrl_pkg::*;
(
  input  CtrlState_t state_i,
  input  logic       reset_i,
  input  logic       mem_ready_i,
  input  logic [5:0] opcode_i,
  output ctrl_out_t  ctrl_o
);

  always_comb begin
    // NOTE: every field gets a default before the case, so no path leaves a
    // field unassigned and no latch is inferred.
    ctrl_o = '0;
    unique case (state_i)
      FETCH: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.alusrcb = ALUSRCB_FOUR;
        ctrl_o.aluop   = ALUOP_ADD;
        ctrl_o.pcsrc   = PCSRC_ALU;
        ctrl_o.irwrite = mem_ready_i;
        ctrl_o.pcwrite = mem_ready_i;
      end
      DECODE: begin
        ctrl_o.alusrcb    = ALUSRCB_IMM_SH;
        ctrl_o.aluop      = ALUOP_ADD;
        ctrl_o.illegal_op = ~is_legal_opcode(opcode_i);
      end
      MEMADR, ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = ALUSRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      MEMRD: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      MEMWB: begin
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      MEMWR: begin
        ctrl_o.mem_req  = 1'b1;
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      EXECUTE: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = ALUSRCB_B;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl_o.regdst   = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      BRANCH: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = ALUSRCB_B;
        ctrl_o.aluop   = ALUOP_SUB;
        ctrl_o.pcsrc   = PCSRC_ALUOUT;
        ctrl_o.branch  = 1'b1;
      end
      ADDIWB: begin
        ctrl_o.regwrite = 1'b1;
      end
      JUMP: begin
        ctrl_o.pcsrc   = PCSRC_JUMP;
        ctrl_o.pcwrite = 1'b1;
      end
      default: ctrl_o = '0;
    endcase

    // Reset wins: strobes off immediately, selects parked at their FETCH values.
    if (reset_i) begin
      ctrl_o         = '0;
      ctrl_o.alusrcb = ALUSRCB_FOUR;
      ctrl_o.aluop   = ALUOP_ADD;
      ctrl_o.pcsrc   = PCSRC_ALU;
    end
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main controller: state register and next-state logic,
// with output decode delegated to main_control_outdec.
module main_control_fsm
  import MainCtrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  main_control_fsm_if.master bus
);

  CtrlState_t state_q, state_d;
  ctrl_out_t  ctrl;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value; the reset is synchronous, checked inside the edge.
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        unique case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   if (bus.mem_ready) state_d = MEMWB;
      MEMWR:   if (bus.mem_ready) state_d = FETCH;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  main_control_outdec u_outdec (
    .state_i     (state_q),
    .reset_i     (reset),
    .mem_ready_i (bus.mem_ready),
    .opcode_i    (bus.opcode),
    .ctrl_o      (ctrl)
  );

  assign bus.mem_req    = ctrl.mem_req;
  assign bus.iord       = ctrl.iord;
  assign bus.memwrite   = ctrl.memwrite;
  assign bus.irwrite    = ctrl.irwrite;
  assign bus.regdst     = ctrl.regdst;
  assign bus.memtoreg   = ctrl.memtoreg;
  assign bus.regwrite   = ctrl.regwrite;
  assign bus.alusrca    = ctrl.alusrca;
  assign bus.alusrcb    = ctrl.alusrcb;
  assign bus.aluop      = ctrl.aluop;
  assign bus.pcsrc      = ctrl.pcsrc;
  assign bus.pcwrite    = ctrl.pcwrite;
  assign bus.branch     = ctrl.branch;
  assign bus.illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: an instruction-level model expands
// each opcode into its expected per-cycle output trace, compared cycle by cycle.
module tb_main_control_fsm;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       illegal_op;
  } out_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  out_t       exp_q[$];
  out_t       obs_q[$];
  logic       rdy_q[$];
  logic [5:0] op_q[$];

  main_control_fsm_if bus_if ();

  main_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector per phase, straight from the per-state output table.
  function automatic out_t mk(input logic mr, io, mw, ir, rd, mt, rw, sa,
                              input logic [1:0] sb, ao, ps,
                              input logic pw, br, il);
    return {mr, io, mw, ir, rd, mt, rw, sa, sb, ao, ps, pw, br, il};
  endfunction

  function automatic out_t v_fetch(input logic r);
    return mk(1, 0, 0, r, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, r, 0, 0);
  endfunction
  function automatic out_t v_reset();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 0);
  endfunction
  function automatic out_t v_decode(input logic il);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0, il);
  endfunction
  function automatic out_t v_addr();   // address/immediate add (lw, sw, addi)
    return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 0);
  endfunction
  function automatic out_t v_memrd();
    return mk(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
  endfunction
  function automatic out_t v_memwb();
    return mk(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
  endfunction
  function automatic out_t v_memwr();
    return mk(1, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
  endfunction

  task automatic push(input out_t e, input logic r, input logic [5:0] o);
    exp_q.push_back(e);
    rdy_q.push_back(r);
    op_q.push_back(o);
  endtask

  // Instruction-level model: fw FETCH wait cycles, mw data-memory wait cycles.
  // Opcode is garbage during FETCH; mem_ready is random where no request is open.
  task automatic model(input logic [5:0] op, input int fw, input int mw);
    logic legal;
    legal = op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    for (int i = 0; i < fw; i++) push(v_fetch(0), 1'b0, 6'($urandom));
    push(v_fetch(1), 1'b1, 6'($urandom));
    push(v_decode(!legal), 1'($urandom), op);
    case (op)
      6'b100011: begin
        push(v_addr(), 1'($urandom), op);
        for (int i = 0; i < mw; i++) push(v_memrd(), 1'b0, op);
        push(v_memrd(), 1'b1, op);
        push(v_memwb(), 1'($urandom), op);
      end
      6'b101011: begin
        push(v_addr(), 1'($urandom), op);
        for (int i = 0; i < mw; i++) push(v_memwr(), 1'b0, op);
        push(v_memwr(), 1'b1, op);
      end
      6'b000000: begin
        push(mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0, 0), 1'($urandom), op);
        push(mk(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0), 1'($urandom), op);
      end
      6'b000100:
        push(mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0, 1, 0), 1'($urandom), op);
      6'b001000: begin
        push(v_addr(), 1'($urandom), op);
        push(mk(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0), 1'($urandom), op);
      end
      6'b000010:
        push(mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0, 0), 1'($urandom), op);
      default: ;
    endcase
    // One idle FETCH cycle proves the instruction returned in the right count.
    push(v_fetch(0), 1'b0, 6'($urandom));
  endtask

  function automatic out_t sample();
    return {bus_if.mem_req, bus_if.iord, bus_if.memwrite, bus_if.irwrite,
            bus_if.regdst, bus_if.memtoreg, bus_if.regwrite, bus_if.alusrca,
            bus_if.alusrcb, bus_if.aluop, bus_if.pcsrc, bus_if.pcwrite,
            bus_if.branch, bus_if.illegal_op};
  endfunction

  task automatic run_seq();
    obs_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      bus_if.opcode    = op_q[i];
      bus_if.mem_ready = rdy_q[i];
      #1;
      obs_q.push_back(sample());
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    rdy_q.delete();
    op_q.delete();
  endtask

  task automatic test_reset();
    out_t obs;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); bus_if.mem_ready = 1'($urandom); #1; obs = sample();
      checks++;
      if (obs !== v_reset()) begin errors++; $display("FAIL reset_init c%0d: got %b want %b", c, obs, v_reset()); end
    end
    @(negedge clk); reset = 1'b0; bus_if.mem_ready = 1'b1; #1; obs = sample();
    checks++;
    if (obs !== v_fetch(1)) begin errors++; $display("FAIL reset_fetch: got %b want %b", obs, v_fetch(1)); end
    @(negedge clk); bus_if.opcode = 6'b100011; bus_if.mem_ready = 1'b0; #1; obs = sample();
    checks++;
    if (obs !== v_decode(0)) begin errors++; $display("FAIL reset_decode: got %b want %b", obs, v_decode(0)); end
    @(negedge clk); #1; obs = sample();
    checks++;
    if (obs !== v_addr()) begin errors++; $display("FAIL reset_memadr: got %b want %b", obs, v_addr()); end
    @(negedge clk); #1; obs = sample();
    checks++;
    if (obs !== v_memrd()) begin errors++; $display("FAIL reset_memrd: got %b want %b", obs, v_memrd()); end
    // Reset for two cycles in MEMRD while memory claims ready.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); reset = 1'b1; bus_if.mem_ready = 1'b1; #1; obs = sample();
      checks++;
      if (obs !== v_reset()) begin errors++; $display("FAIL reset_midinstr c%0d: got %b want %b", c, obs, v_reset()); end
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); reset = 1'b0; bus_if.mem_ready = 1'b0; #1; obs = sample();
      checks++;
      if (obs !== v_fetch(0)) begin errors++; $display("FAIL reset_post c%0d: got %b want %b", c, obs, v_fetch(0)); end
    end
  endtask

  task automatic test_lw();
    clear_model(); model(6'b100011, 0, 0); run_seq();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL lw c%0d: got %b want %b", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_rtype_beq();
    clear_model(); model(6'b000000, 0, 0); model(6'b000100, 0, 0); run_seq();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rtype_beq c%0d: got %b want %b", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_sw_wait();
    clear_model(); model(6'b101011, 0, 3); run_seq();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL sw_wait c%0d: got %b want %b", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_fetch_wait();
    clear_model(); model(6'b001000, 2, 0); run_seq();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL fetch_wait c%0d: got %b want %b", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_illegal_jump();
    clear_model(); model(6'b111111, 0, 0); model(6'b000010, 0, 0); run_seq();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL illegal_jump c%0d: got %b want %b", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000000};
    clear_model();
    for (int n = 0; n < 60; n++) begin
      ops[6] = 6'($urandom);
      model(ops[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 3));
    end
    run_seq();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random c%0d: got %b want %b", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset            = 1'b1;
    bus_if.opcode    = 6'b000000;
    bus_if.mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_rtype_beq();
    test_sw_wait();
    test_fetch_wait();
    test_illegal_jump();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
